// File: rtl/puf_tmv_collector.sv
// Sweeps every PUF address, samples the response NSAMP times, and majority-votes each bit.
// Emits the voted byte, a per-bit instability mask and the address over a valid/ready handshake.
module puf_tmv_collector #(
    parameter int unsigned NSAMP  = 7,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] puf_addr,
    input  logic [DATA_W-1:0] puf_out,
    output logic [DATA_W-1:0] resp_data,
    output logic [DATA_W-1:0] resp_unstable,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(NSAMP + 1);
    localparam int unsigned SET_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SAMPLE, S_EVAL, S_EMIT, S_DONE
    } state_t;

    state_t            state, state_n;
    logic [SET_W-1:0]  set_cnt, set_cnt_n;
    logic [CNT_W-1:0]  smp_cnt, smp_cnt_n;
    logic [CNT_W-1:0]  bit_cnt   [DATA_W];
    logic [CNT_W-1:0]  bit_cnt_n [DATA_W];
    logic [ADDR_W-1:0] puf_addr_n, resp_addr_n;
    logic [DATA_W-1:0] resp_data_n, resp_unstable_n;
    logic              resp_valid_n, busy_n, done_n;

    // State and datapath registers; reset discards any partial sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            set_cnt       <= '0;
            smp_cnt       <= '0;
            for (int i = 0; i < DATA_W; i++) bit_cnt[i] <= '0;
            puf_addr      <= '0;
            resp_addr     <= '0;
            resp_data     <= '0;
            resp_unstable <= '0;
            resp_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            set_cnt       <= set_cnt_n;
            smp_cnt       <= smp_cnt_n;
            for (int i = 0; i < DATA_W; i++) bit_cnt[i] <= bit_cnt_n[i];
            puf_addr      <= puf_addr_n;
            resp_addr     <= resp_addr_n;
            resp_data     <= resp_data_n;
            resp_unstable <= resp_unstable_n;
            resp_valid    <= resp_valid_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n         = state;
        set_cnt_n       = set_cnt;
        smp_cnt_n       = smp_cnt;
        for (int i = 0; i < DATA_W; i++) bit_cnt_n[i] = bit_cnt[i];
        puf_addr_n      = puf_addr;
        resp_addr_n     = resp_addr;
        resp_data_n     = resp_data;
        resp_unstable_n = resp_unstable;
        resp_valid_n    = resp_valid;
        busy_n          = busy;
        done_n          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_SETTLE;
                    puf_addr_n = '0;
                    set_cnt_n  = '0;
                    busy_n     = 1'b1;
                end
            end
            S_SETTLE: begin
                smp_cnt_n = '0;
                for (int i = 0; i < DATA_W; i++) bit_cnt_n[i] = '0;
                if (set_cnt == SET_W'(SETTLE - 1)) begin
                    state_n = S_SAMPLE;
                end else begin
                    set_cnt_n = set_cnt + SET_W'(1);
                end
            end
            S_SAMPLE: begin
                for (int i = 0; i < DATA_W; i++) begin
                    bit_cnt_n[i] = bit_cnt[i] + CNT_W'(puf_out[i]);
                end
                if (smp_cnt == CNT_W'(NSAMP - 1)) begin
                    state_n = S_EVAL;
                end else begin
                    smp_cnt_n = smp_cnt + CNT_W'(1);
                end
            end
            S_EVAL: begin
                for (int i = 0; i < DATA_W; i++) begin
                    resp_data_n[i]     = (bit_cnt[i] > CNT_W'(NSAMP / 2));
                    resp_unstable_n[i] = (bit_cnt[i] != '0) && (bit_cnt[i] != CNT_W'(NSAMP));
                end
                resp_addr_n  = puf_addr;
                resp_valid_n = 1'b1;
                state_n      = S_EMIT;
            end
            S_EMIT: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    if (puf_addr == {ADDR_W{1'b1}}) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        puf_addr_n = puf_addr + ADDR_W'(1);
                        set_cnt_n  = '0;
                        state_n    = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
